// File: rtl/micro_uart_bridge.sv
// Byte-stream master for micro_uart: status polling, TX-data writes, RX-data reads into a one-entry buffer.
// Optional feature macro: MICRO_UART_BRIDGE_IRQ_EN (IRQ/tx_valid-driven polling instead of the poll timer).
module micro_uart_bridge #(
  parameter int                WIDTHD      = 18,
  parameter logic [WIDTHD-1:0] CTRL_INIT   = 'h3,
  parameter int                POLL_CYCLES = 16
) (
  input  logic              clock,
  input  logic              clock_sreset,
  output logic [3:0]        address,
  output logic [WIDTHD-1:0] writedata,
  input  logic [WIDTHD-1:0] readdata,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  input  logic              irq,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun
);

  typedef enum logic [2:0] {INIT, IDLE, STAT, TXW, RXR} state_t;

  state_t state;
  logic   rd_accept;
  logic   wr_accept;
  logic   rx_load;
  logic   unused_bits;

`ifdef MICRO_UART_BRIDGE_IRQ_EN
  logic irq_q;
`else
  localparam int CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] POLL_RELOAD = CW'(POLL_CYCLES - 1);
  logic [CW-1:0] poll_cnt;
`endif

  assign rd_accept   = read && !waitrequest;
  assign wr_accept   = write && !waitrequest;
  assign rx_load     = (state == RXR) && rd_accept;
  // The stream handshake must coincide with the bus accept, which depends on the live waitrequest.
  assign tx_ready    = (state == TXW) && wr_accept;
  assign unused_bits = ^{irq, readdata};

  always_ff @(posedge clock or posedge clock_sreset) begin
    if (clock_sreset) begin
      state      <= INIT;
      address    <= 4'd0;
      writedata  <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef MICRO_UART_BRIDGE_IRQ_EN
      irq_q      <= 1'b0;
`else
      poll_cnt   <= POLL_RELOAD;
`endif
    end else begin
`ifdef MICRO_UART_BRIDGE_IRQ_EN
      irq_q <= irq;
`endif
      // A load in the same cycle as a consume keeps the buffer full with the new byte.
      if (rx_load) begin
        rx_data  <= readdata[7:0];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        INIT: begin
          if (!write) begin
            write     <= 1'b1;
            address   <= 4'd0;
            writedata <= CTRL_INIT;
          end else if (!waitrequest) begin
            write     <= 1'b0;
            writedata <= '0;
            state     <= IDLE;
          end
        end
        IDLE: begin
`ifdef MICRO_UART_BRIDGE_IRQ_EN
          if (irq_q || tx_valid) state <= STAT;
`else
          if (poll_cnt == '0) begin
            poll_cnt <= POLL_RELOAD;
            state    <= STAT;
          end else begin
            poll_cnt <= poll_cnt - 1'b1;
          end
`endif
        end
        // Receive wins over transmit so the UART's single RX register drains first.
        STAT: begin
          if (!read) begin
            read    <= 1'b1;
            address <= 4'd1;
          end else if (!waitrequest) begin
            read <= 1'b0;
            if (readdata[2]) rx_overrun <= 1'b1;
            if (readdata[1] && !rx_valid)     state <= RXR;
            else if (readdata[0] && tx_valid) state <= TXW;
            else                              state <= IDLE;
          end
        end
        TXW: begin
          if (!write) begin
            write     <= 1'b1;
            address   <= 4'd2;
            writedata <= WIDTHD'(tx_data);
          end else if (!waitrequest) begin
            write     <= 1'b0;
            writedata <= '0;
            state     <= IDLE;
          end
        end
        RXR: begin
          if (!read) begin
            read    <= 1'b1;
            address <= 4'd3;
          end else if (!waitrequest) begin
            read  <= 1'b0;
            state <= STAT;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
